alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external arithmetic unit between two requesters.
// Each accepted request runs IDLE -> ISSUE -> WAIT -> RESP. The result is
// returned to the requester that owns the operation.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       fun0,
  input  logic [1:0]       fun1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             res_cout,
  output logic             res_flag,
  output logic [WIDTH-1:0] arith_in1,
  output logic [WIDTH-1:0] arith_in2,
  output logic [1:0]       arith_fun,
  output logic             arith_en,
  input  logic [WIDTH-1:0] arith_out,
  input  logic             arith_cout,
  input  logic             arith_flag
);

  // Counter only needs to hold LAT-1; keep at least one bit for LAT=1
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          win_valid;
  logic          win_sel;
  logic          take;

  assign win_valid = req0 | req1;
  assign take      = (state == IDLE) && win_valid;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // last_gnt remembers who was served last; resetting it to 1 favours requester 0
  logic last_gnt;

  // Round-robin winner: on conflict the requester not served last wins
  always_comb begin
    win_sel = 1'b0;
    if (req0 && req1) begin
      win_sel = ~last_gnt;
    end else begin
      win_sel = ~req0;
    end
  end

  // Pointer follows every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (take) begin
      last_gnt <= win_sel;
    end
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is idle
  always_comb begin
    win_sel = ~req0;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus grant/done/enable strobes
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    arith_en   = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid && !rst) begin
          gnt0       = ~win_sel;
          gnt1       = win_sel;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        arith_en   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        done0      = ~owner;
        done1      = owner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture at grant; the values stay frozen for the whole operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arith_in1 <= '0;
      arith_in2 <= '0;
      arith_fun <= '0;
      owner     <= 1'b0;
    end else if (take) begin
      owner <= win_sel;
      if (win_sel) begin
        arith_in1 <= a1;
        arith_in2 <= b1;
        arith_fun <= fun1;
      end else begin
        arith_in1 <= a0;
        arith_in2 <= b0;
        arith_fun <= fun0;
      end
    end
  end

  // Latency counter: loaded at issue and counted down while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= CW'(LAT - 1);
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Result registers: loaded when the unit output is due, then held until the next result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res      <= '0;
      res_cout <= 1'b0;
      res_flag <= 1'b0;
    end else if ((state == WAIT) && (cnt == '0)) begin
      res      <= arith_out;
      res_cout <= arith_cout;
      res_flag <= arith_flag;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter.
// u1 is a LAT=1 instance and u3 is a LAT=3 instance. Each has a simple
// arithmetic-unit model of matching depth.
module tb_alu_arbiter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // u1 (LAT=1) signals
  logic         req0, req1, gnt0, gnt1, done0, done1;
  logic [1:0]   fun0, fun1, afun;
  logic [W-1:0] a0, b0, a1, b1, res, ain1, ain2, aout;
  logic         res_cout, res_flag, aen, acout, aflag;

  // u3 (LAT=3) signals
  logic         q_req0, q_gnt0, q_gnt1, q_done0, q_done1;
  logic [1:0]   q_afun;
  logic [W-1:0] q_a0, q_b0, q_res, q_ain1, q_ain2, q_aout;
  logic         q_res_cout, q_res_flag, q_aen, q_acout, q_aflag;

  alu_arbiter #(.WIDTH(W), .LAT(1)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .fun0(fun0), .fun1(fun1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .res(res), .res_cout(res_cout), .res_flag(res_flag),
    .arith_in1(ain1), .arith_in2(ain2), .arith_fun(afun), .arith_en(aen),
    .arith_out(aout), .arith_cout(acout), .arith_flag(aflag)
  );

  alu_arbiter #(.WIDTH(W), .LAT(3)) u3 (
    .clk(clk), .rst(rst), .req0(q_req0), .req1(1'b0), .fun0(2'b00), .fun1(2'b00),
    .a0(q_a0), .b0(q_b0), .a1('0), .b1('0), .gnt0(q_gnt0), .gnt1(q_gnt1),
    .done0(q_done0), .done1(q_done1), .res(q_res), .res_cout(q_res_cout), .res_flag(q_res_flag),
    .arith_in1(q_ain1), .arith_in2(q_ain2), .arith_fun(q_afun), .arith_en(q_aen),
    .arith_out(q_aout), .arith_cout(q_acout), .arith_flag(q_aflag)
  );

  // Arithmetic unit behaviour: {flag(zero), cout, result}
  function automatic logic [W+1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [1:0] f);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    c = 1'b0;
    case (f)
      2'b00:   begin s = {1'b0, x} + {1'b0, y};          r = s[W-1:0]; c = s[W]; end
      2'b01:   begin s = {1'b0, x} + {1'b0, ~y} + 1'b1;  r = s[W-1:0]; c = s[W]; end
      2'b10:   r = x & y;
      default: r = x ^ y;
    endcase
    return {(r == '0), c, r};
  endfunction

  // Unit models: one pipeline stage for u1, three for u3
  logic [W+1:0] p1, s0, s1, s2;
  always_ff @(posedge clk) begin
    p1 <= calc(ain1, ain2, afun);
    s0 <= calc(q_ain1, q_ain2, q_afun);
    s1 <= s0;
    s2 <= s1;
  end
  assign {aflag, acout, aout}       = p1;
  assign {q_aflag, q_acout, q_aout} = s2;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs are driven there and outputs sampled #1 later
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic exp_win [3];
    int   en_count;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    exp_win[0] = 1'b0; exp_win[1] = 1'b1; exp_win[2] = 1'b0;
`else
    exp_win[0] = 1'b0; exp_win[1] = 1'b0; exp_win[2] = 1'b0;
`endif

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; fun0 = 2'b00; fun1 = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    q_req0 = 1'b0; q_a0 = '0; q_b0 = '0;
    applyStimulus();
    #1;
    checkOutput("reset_gnt",  {gnt0, gnt1, done0, done1}, 4'b0000);
    checkOutput("reset_en",   aen, 1'b0);
    checkOutput("reset_in1",  ain1, 16'd0);
    checkOutput("reset_res",  {res_flag, res_cout, res}, 18'd0);
    checkOutput("reset_q_res", q_res, 16'd0);
    applyStimulus();
    rst = 1'b0;

    // Requester 0 add: 17 + 12
    applyStimulus();
    req0 = 1'b1; fun0 = 2'b00; a0 = 16'd17; b0 = 16'd12;
    #1;
    checkOutput("t1_gnt", {gnt0, gnt1}, 2'b10);
    applyStimulus();
    req0 = 1'b0; a0 = 16'd99; b0 = 16'd99;
    #1;
    checkOutput("t1_issue_en", {aen, gnt0}, 2'b10);
    checkOutput("t1_issue_ops", {ain1, ain2}, {16'd17, 16'd12});
    applyStimulus();
    #1;
    checkOutput("t1_wait_en", {aen, done0}, 2'b00);
    checkOutput("t1_wait_hold", ain1, 16'd17);
    applyStimulus();
    #1;
    checkOutput("t1_done", {done0, done1, gnt1}, 3'b100);
    checkOutput("t1_res", {res_flag, res_cout, res}, {2'b00, 16'd29});
    applyStimulus();
    #1;
    checkOutput("t1_res_hold", {done0, res}, {1'b0, 16'd29});

    // Requester 1 subtract: 17 - 12
    req1 = 1'b1; fun1 = 2'b01; a1 = 16'd17; b1 = 16'd12;
    #1;
    checkOutput("t2_gnt", {gnt0, gnt1}, 2'b01);
    applyStimulus();
    req1 = 1'b0;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("t2_done", {done0, done1}, 2'b01);
    checkOutput("t2_res", res, 16'd5);

    // Both requesters held high: the arbitration order depends on the build
    applyStimulus();
    req0 = 1'b1; fun0 = 2'b00; a0 = 16'd1;  b0 = 16'd2;
    req1 = 1'b1; fun1 = 2'b01; a1 = 16'd10; b1 = 16'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("t3_gnt%0d", k), {gnt0, gnt1}, {~exp_win[k], exp_win[k]});
      applyStimulus();
      applyStimulus();
      applyStimulus();
      #1;
      checkOutput($sformatf("t3_done%0d", k), {done0, done1}, {~exp_win[k], exp_win[k]});
      checkOutput($sformatf("t3_res%0d", k), res, exp_win[k] ? 16'd6 : 16'd3);
      applyStimulus();
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    checkOutput("t3_drop_no_gnt", {gnt0, gnt1}, 2'b00);

    // Reset while an operation for requester 0 is waiting on the unit
    applyStimulus();
    req0 = 1'b1; fun0 = 2'b00; a0 = 16'd5; b0 = 16'd6;
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    #1;
    checkOutput("t4_rst_outs", {gnt0, gnt1, done0, done1, aen}, 5'b00000);
    checkOutput("t4_rst_regs", {afun, ain1, ain2}, 34'd0);
    checkOutput("t4_rst_res", {res_flag, res_cout, res}, 18'd0);
    applyStimulus();
    #1;
    checkOutput("t4_no_done", {done0, gnt0}, 2'b00);
    rst = 1'b0;
    #1;
    checkOutput("t4_regrant", gnt0, 1'b1);
    applyStimulus();
    req0 = 1'b0;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("t4_done", {done0, done1}, 2'b10);
    checkOutput("t4_res", res, 16'd11);

    // LAT=3 instance: done comes five cycles after the grant
    applyStimulus();
    q_req0 = 1'b1; q_a0 = 16'd100; q_b0 = 16'd1;
    #1;
    checkOutput("t5_gnt", q_gnt0, 1'b1);
    en_count = 0;
    for (int k = 1; k <= 5; k++) begin
      applyStimulus();
      if (k == 1) q_req0 = 1'b0;
      #1;
      if (q_aen) en_count++;
      if (k < 5) checkOutput($sformatf("t5_early_done%0d", k), q_done0, 1'b0);
    end
    checkOutput("t5_done", {q_done0, q_done1}, 2'b10);
    checkOutput("t5_res", q_res, 16'd101);
    checkOutput("t5_en_once", en_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
